// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request and Data_Memory signals of the load/store unit
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       size;
  logic             is_unsigned;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] load_data;
  logic             stall;
  logic             addr_err;
  logic             err_sticky;
  logic [WIDTH-1:0] mem_A;
  logic [WIDTH-1:0] mem_WD;
  logic             mem_WE;
  logic [WIDTH-1:0] mem_RD;

  modport slave (
    input  mem_read, mem_write, size, is_unsigned, addr, wdata, mem_RD,
    output load_data, stall, addr_err, err_sticky, mem_A, mem_WD, mem_WE
  );

  modport master (
    output mem_read, mem_write, size, is_unsigned, addr, wdata, mem_RD,
    input  load_data, stall, addr_err, err_sticky, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with sub-word read-modify-write
// Loads extract/extend a lane of the word-only memory; byte/half stores take two cycles.
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100
) (
  input logic              CLK,
  input logic              RST,
  load_store_unit_if.slave bus
);
  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] word_q;
  logic [15:0]      wdata_q;
  logic [1:0]       size_q;
  logic             err_q;

  logic             req;
  logic             misaligned;
  logic             out_of_range;
  logic             err;
  logic             word_store;
  logic             sub_store;
  logic [WIDTH-1:0] word_idx;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [WIDTH-1:0] merged;

  assign req          = bus.mem_read | bus.mem_write;
  assign word_idx     = {2'b00, bus.addr[WIDTH-1:2]};
  assign misaligned   = ((bus.size == 2'b01) & bus.addr[0])
                      | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00))
                      | (bus.size == 2'b11);
  assign out_of_range = word_idx >= WIDTH'(DEPTH);
  // Requests are only evaluated in IDLE; RMW_WR works from latched copies.
  assign err          = (state == IDLE) & req & (misaligned | out_of_range);
  assign word_store   = (state == IDLE) & bus.mem_write & ~err & (bus.size == 2'b10);
  assign sub_store    = (state == IDLE) & bus.mem_write & ~err & ~bus.size[1];

  assign lane_byte = bus.mem_RD[{bus.addr[1:0], 3'b000} +: 8];
  assign lane_half = bus.mem_RD[{bus.addr[1], 4'b0000} +: 16];

  always_comb begin
    bus.load_data = bus.mem_RD;
    case (bus.size)
      2'b00:   bus.load_data = bus.is_unsigned ? {{(WIDTH-8){1'b0}}, lane_byte}
                                               : {{(WIDTH-8){lane_byte[7]}}, lane_byte};
      2'b01:   bus.load_data = bus.is_unsigned ? {{(WIDTH-16){1'b0}}, lane_half}
                                               : {{(WIDTH-16){lane_half[15]}}, lane_half};
      default: ;
    endcase
    if (err) bus.load_data = '0;
  end

  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_next  = state;
    bus.stall   = 1'b0;
    bus.mem_WE  = 1'b0;
    bus.mem_WD  = bus.wdata;
    bus.mem_A   = word_idx;
    unique case (state)
      IDLE: begin
        if (sub_store) begin
          bus.stall  = 1'b1;
          state_next = RMW_WR;
        end else if (word_store) begin
          bus.mem_WE = 1'b1;
        end
      end
      RMW_WR: begin
        bus.mem_A  = {2'b00, addr_q[WIDTH-1:2]};
        bus.mem_WD = merged;
        bus.mem_WE = 1'b1;
        state_next = IDLE;
      end
    endcase
    if (RST) begin
      bus.stall  = 1'b0;
      bus.mem_WE = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state <= state_next;
      if (err) err_q <= 1'b1;
      if (sub_store) begin
        addr_q  <= bus.addr;
        word_q  <= bus.mem_RD;
        wdata_q <= bus.wdata[15:0];
        size_q  <= bus.size;
      end
    end
  end

  assign bus.addr_err   = err;
  assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-level memory model
module tb_load_store_unit;
  localparam int DEPTH = 100;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Data_Memory stand-in: asynchronous read, write on rising edge
  logic [31:0] mem [0:DEPTH-1];
  assign bus.mem_RD = (bus.mem_A < 32'(DEPTH)) ? mem[bus.mem_A[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (bus.mem_WE && bus.mem_A < 32'(DEPTH)) begin
      mem[bus.mem_A[6:0]] <= bus.mem_WD;
    end
  end

  // Reference view of memory contents and expected outputs
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        sticky_m;
  logic        e_chk, e_ld_chk, e_stall, e_we, e_err;
  logic [31:0] e_ld, e_wd, e_a;
  string       tag;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ld, wds, as;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return (a / 4) >= 32'(DEPTH);
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = (sz == 2'd0) ? 1 : 2;
    return int'(a[1:0]) - (int'(a[1:0]) % nb);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
    logic [31:0] mask, v;
    int nb;
    if (sz >= 2'd2) return w;
    nb   = (sz == 2'd0) ? 1 : 2;
    mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (w >> (8 * lane_off(sz, a))) & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    int nb, off;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    nb  = (sz == 2'd0) ? 1 : 2;
    off = lane_off(sz, a);
    for (int i = 0; i < nb; i++) b[off+i] = wd[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  always @(negedge clk) begin
    if (e_chk) begin
      check("stall", {31'b0, bus.stall}, {31'b0, e_stall});
      check("mem_WE", {31'b0, bus.mem_WE}, {31'b0, e_we});
      check("addr_err", {31'b0, bus.addr_err}, {31'b0, e_err});
      check("err_sticky", {31'b0, bus.err_sticky}, {31'b0, sticky_m});
      check("mem_A", bus.mem_A, e_a);
      if (e_we) check("mem_WD", bus.mem_WD, e_wd);
      if (e_ld_chk) check("load_data", bus.load_data, e_ld);
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic op(input string t, input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] ld_o, output logic [31:0] wd_o, output logic [31:0] a_o);
    logic        bad;
    int          idx;
    logic [31:0] word, nw;
    tag = t;
    bus.mem_read = rd; bus.mem_write = wr; bus.size = sz;
    bus.is_unsigned = uns; bus.addr = a; bus.wdata = wd;
    bad  = model_err(rd, wr, sz, a);
    idx  = int'(a >> 2);
    word = (idx < DEPTH) ? ref_mem[idx] : 32'h0;
    e_err = bad; e_a = a >> 2; e_wd = wd; e_ld_chk = 1'b1;
    e_ld  = bad ? 32'h0 : model_load(word, sz, uns, a);
    e_stall = wr && !bad && (sz != 2'd2);
    e_we    = wr && !bad && (sz == 2'd2);
    e_chk   = 1'b1;
    @(negedge clk);
    ld_o = bus.load_data; wd_o = bus.mem_WD; a_o = bus.mem_A;
    @(posedge clk); #1;
    if (bad) sticky_m = 1'b1;
    if (e_we) ref_mem[idx] = wd;
    if (e_stall) begin
      nw = model_merge(word, sz, a, wd);
      e_stall = 1'b0; e_we = 1'b1; e_wd = nw; e_err = 1'b0; e_ld_chk = 1'b0;
      @(negedge clk);
      wd_o = bus.mem_WD; a_o = bus.mem_A;
      @(posedge clk); #1;
      ref_mem[idx] = nw;
    end
    e_chk = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; sticky_m = 1'b0; e_chk = 1'b0; e_ld_chk = 1'b0;
    e_stall = 1'b0; e_we = 1'b0; e_err = 1'b0; e_ld = '0; e_wd = '0; e_a = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    tag = "reset";
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.size = 2'b00;
    bus.is_unsigned = 1'b0; bus.addr = 32'h8; bus.wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'b0, bus.stall}, 32'h0);
    check("rst_we", {31'b0, bus.mem_WE}, 32'h0);
    check("rst_sticky", {31'b0, bus.err_sticky}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    op("sw_8", 0, 1, 2'd2, 0, 32'h8, 32'hDEAD_BEEF, ld, wds, as);
    tag = "sw_8"; check("lit_mem_A", as, 32'd2);
    op("lw_8", 1, 0, 2'd2, 0, 32'h8, 32'h0, ld, wds, as);
    tag = "lw_8"; check("lit_ld", ld, 32'hDEAD_BEEF);
    op("sb_9", 0, 1, 2'd0, 0, 32'h9, 32'h55, ld, wds, as);
    tag = "sb_9"; check("lit_wd", wds, 32'hDEAD_55EF);
    op("lw_8b", 1, 0, 2'd2, 0, 32'h8, 32'h0, ld, wds, as);
    tag = "lw_8b"; check("lit_ld", ld, 32'hDEAD_55EF);

    op("sw_80ff", 0, 1, 2'd2, 0, 32'h8, 32'h80FF_7F01, ld, wds, as);
    op("lb_A", 1, 0, 2'd0, 0, 32'hA, 32'h0, ld, wds, as);
    tag = "lb_A"; check("lit_ld", ld, 32'hFFFF_FFFF);
    op("lbu_A", 1, 0, 2'd0, 1, 32'hA, 32'h0, ld, wds, as);
    tag = "lbu_A"; check("lit_ld", ld, 32'h0000_00FF);
    op("lh_A", 1, 0, 2'd1, 0, 32'hA, 32'h0, ld, wds, as);
    tag = "lh_A"; check("lit_ld", ld, 32'hFFFF_80FF);
    op("lhu_8", 1, 0, 2'd1, 1, 32'h8, 32'h0, ld, wds, as);
    tag = "lhu_8"; check("lit_ld", ld, 32'h0000_7F01);
    op("lb_9", 1, 0, 2'd0, 0, 32'h9, 32'h0, ld, wds, as);
    op("lb_B", 1, 0, 2'd0, 0, 32'hB, 32'h0, ld, wds, as);
    tag = "lb_B"; check("lit_ld", ld, 32'hFFFF_FF80);

    op("sh_A", 0, 1, 2'd1, 0, 32'hA, 32'h1234_ABCD, ld, wds, as);
    tag = "sh_A"; check("lit_wd", wds, 32'hABCD_7F01);
    op("sb_B", 0, 1, 2'd0, 0, 32'hB, 32'hAA, ld, wds, as);
    op("sb_8", 0, 1, 2'd0, 0, 32'h8, 32'h33, ld, wds, as);
    tag = "sb_8"; check("lit_wd", wds, 32'hAACD_7F33);
    op("rdwr_C", 1, 1, 2'd2, 0, 32'hC, 32'h1122_3344, ld, wds, as);
    tag = "rdwr_C"; check("lit_ld", ld, 32'h0);
    op("idle_C", 0, 0, 2'd2, 0, 32'hC, 32'h0, ld, wds, as);
    tag = "idle_C"; check("lit_ld", ld, 32'h1122_3344);

    op("lw_6", 1, 0, 2'd2, 0, 32'h6, 32'h0, ld, wds, as);
    tag = "lw_6"; check("lit_ld", ld, 32'h0);
    op("sh_3", 0, 1, 2'd1, 0, 32'h3, 32'hFFFF, ld, wds, as);
    op("sz11", 1, 0, 2'd3, 0, 32'h0, 32'h0, ld, wds, as);
    op("sw_oor", 0, 1, 2'd2, 0, 32'(4*DEPTH), 32'h1234_5678, ld, wds, as);
    op("lw_last", 1, 0, 2'd2, 0, 32'(4*(DEPTH-1)), 32'h0, ld, wds, as);
    op("lbu_last", 1, 0, 2'd0, 1, 32'(4*DEPTH-1), 32'h0, ld, wds, as);
    tag = "sticky"; check("lit_sticky", {31'b0, bus.err_sticky}, 32'h1);

    op("sw_m1", 0, 1, 2'd2, 0, 32'h4, 32'hCAFE_F00D, ld, wds, as);
    tag = "rst_rmw";
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.size = 2'd1;
    bus.is_unsigned = 1'b0; bus.addr = 32'h4; bus.wdata = 32'h1234;
    @(negedge clk);
    check("c0_stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("c1_we", {31'b0, bus.mem_WE}, 32'h0);
    check("c1_stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clk); #1 rst = 1'b0; sticky_m = 1'b0;
    bus.mem_write = 1'b0; bus.size = 2'd2;
    @(negedge clk);
    check("post_stall", {31'b0, bus.stall}, 32'h0);
    check("post_we", {31'b0, bus.mem_WE}, 32'h0);
    check("post_sticky", {31'b0, bus.err_sticky}, 32'h0);
    @(posedge clk); #1;
    check("mem1", mem[1], 32'hCAFE_F00D);
    op("lw_4", 1, 0, 2'd2, 0, 32'h4, 32'h0, ld, wds, as);
    tag = "lw_4"; check("lit_ld", ld, 32'hCAFE_F00D);
    op("sw_after", 0, 1, 2'd2, 0, 32'h10, 32'h0BAD_CAFE, ld, wds, as);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
